vga_frame_capture: RTL and testbench

//  Receive side of the board's VGA stream: watches vsync/video_on/pixel strobe/rgb and

---
 rtl/vga_frame_capture.sv | 170 +++++++++++++++++
 tb/tb_vga_frame_capture.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_capture.sv
// vga_frame_capture: samples a GRID_X x GRID_Y grid of grayscale pixels from an
// incoming VGA stream into a small frame memory, with a frame-level start/busy/done
// handshake and an optional continuous re-arm mode.
//
// Ports:
//   clock, reset  rising-edge clock; synchronous active-low reset
//   start         1-cycle capture request, honoured only in IDLE
//   continuous    re-arm after each completed frame (sampled at frame completion)
//   vsync         incoming vertical sync (VSYNC_ACTIVE marks retrace)
//   video_on      incoming active-video flag
//   pix_en        pixel strobe
//   rgb           {R,G,B} pixel value, valid with pix_en
//   mem_we        memory write strobe, one cycle per sample
//   mem_addr      write address = row*GRID_X + col
//   mem_wdata     grayscale sample
//   busy          high while armed or capturing (incl. the done/err cycle)
//   done          1-cycle pulse after a full frame has been written
//   err           1-cycle pulse when a capture is aborted by an early vsync
module vga_frame_capture #(
  parameter int unsigned H_DISPLAY    = 640,
  parameter int unsigned V_DISPLAY    = 480,
  parameter int unsigned GRID_X       = 4,
  parameter int unsigned GRID_Y       = 4,
  parameter int unsigned ADDR_W       = 4,
  parameter logic        VSYNC_ACTIVE = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              vsync,
  input  logic              video_on,
  input  logic              pix_en,
  input  logic [23:0]       rgb,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CW   = H_DISPLAY / GRID_X;
  localparam int unsigned CH   = V_DISPLAY / GRID_Y;
  localparam int unsigned PX_W = $clog2(H_DISPLAY + 1);
  localparam int unsigned PY_W = $clog2(V_DISPLAY + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t            state;
  logic              seen_vsync;
  logic [PX_W-1:0]   px;
  logic [PY_W-1:0]   py;
  logic              video_on_q;

  logic              pix_valid;
  logic              line_end;
  logic              vsync_act;
  logic              col_hit;
  logic              row_hit;
  int unsigned       col_idx;
  int unsigned       row_idx;
  logic [ADDR_W-1:0] sample_addr;
  logic [9:0]        gray_sum;

  assign pix_valid = pix_en & video_on;
  assign line_end  = video_on_q & ~video_on;
  assign vsync_act = (vsync == VSYNC_ACTIVE);

  // R + 2G + B fits in 10 bits (max 1020), so >>2 is always 0..255.
  assign gray_sum = 10'(rgb[23:16]) + {1'b0, rgb[15:8], 1'b0} + 10'(rgb[7:0]);

  // Decode whether the current pixel position is a grid sample point.
  always_comb begin
    col_hit = 1'b0;
    col_idx = 0;
    for (int unsigned c = 0; c < GRID_X; c++) begin
      if (px == PX_W'(CW * c + CW / 2)) begin
        col_hit = 1'b1;
        col_idx = c;
      end
    end
    row_hit = 1'b0;
    row_idx = 0;
    for (int unsigned r = 0; r < GRID_Y; r++) begin
      if (py == PY_W'(CH * r + CH / 2)) begin
        row_hit = 1'b1;
        row_idx = r;
      end
    end
    sample_addr = ADDR_W'(row_idx * GRID_X + col_idx);
  end

  // Capture FSM, pixel/line counters and registered memory write port.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      seen_vsync <= 1'b0;
      px         <= '0;
      py         <= '0;
      video_on_q <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      video_on_q <= video_on;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            state      <= ARM;
            seen_vsync <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ARM: begin
          // Enter CAPTURE only on the trailing edge of a retrace interval.
          busy <= 1'b1;
          px   <= '0;
          py   <= '0;
          if (vsync_act) begin
            seen_vsync <= 1'b1;
          end else if (seen_vsync) begin
            state      <= CAPTURE;
            seen_vsync <= 1'b0;
          end
        end
        CAPTURE: begin
          busy <= 1'b1;
          if (vsync_act) begin
            // Early retrace: abort, and treat this retrace as the re-arm point.
            err        <= 1'b1;
            state      <= ARM;
            seen_vsync <= 1'b1;
          end else begin
            if (pix_valid && col_hit && row_hit) begin
              mem_we    <= 1'b1;
              mem_addr  <= sample_addr;
              mem_wdata <= gray_sum[9:2];
            end
            if (pix_valid && px != PX_W'(H_DISPLAY)) begin
              px <= px + PX_W'(1);
            end
            if (line_end) begin
              px <= '0;
              py <= py + PY_W'(1);
              if (py == PY_W'(V_DISPLAY - 1)) begin
                done       <= 1'b1;
                seen_vsync <= 1'b0;
                state      <= continuous ? ARM : IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed testbench for vga_frame_capture using a reduced 16x16 display
// (4x4 grid: samples at x,y in {2,6,10,14}).
module tb_vga_frame_capture;

  localparam int unsigned H  = 16;
  localparam int unsigned V  = 16;
  localparam int unsigned GX = 4;
  localparam int unsigned GY = 4;
  localparam int unsigned CW = H / GX;
  localparam int unsigned CH = V / GY;

  logic        clock;
  logic        reset;
  logic        start;
  logic        continuous;
  logic        vsync;
  logic        video_on;
  logic        pix_en;
  logic [23:0] rgb;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  vga_frame_capture #(
    .H_DISPLAY(H), .V_DISPLAY(V), .GRID_X(GX), .GRID_Y(GY),
    .ADDR_W(4), .VSYNC_ACTIVE(1'b0)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .continuous(continuous),
    .vsync(vsync), .video_on(video_on), .pix_en(pix_en), .rgb(rgb),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Write/pulse log gathered away from the active edge.
  logic [3:0] wr_addr [0:255];
  logic [7:0] wr_data [0:255];
  int wr_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int busy_low_cnt = 0;

  always @(negedge clock) begin
    if (mem_we && wr_cnt < 256) begin
      wr_addr[wr_cnt] = mem_addr;
      wr_data[wr_cnt] = mem_wdata;
    end
    if (mem_we) wr_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (!busy) busy_low_cnt++;
  end

  int passed = 0;
  int total = 0;
  int fails = 0;
  int rst_y = -1;
  int rst_x = -1;
  logic snap_we;
  logic snap_busy;
  int base_wr, base_done, base_err, base_low;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] color(input int mode, input int x, input int y);
    logic [7:0] xb;
    logic [7:0] yb;
    xb = 8'(x);
    yb = 8'(y);
    case (mode)
      1:       return 24'hFFFFFF;
      2:       return 24'h00FF00;
      default: return {xb, yb, 8'h00};
    endcase
  endfunction

  // Expected grayscale for sample index i with the gradient pattern.
  function automatic logic [31:0] exp_grad(input int i);
    int x;
    int y;
    x = CW * (i % GX) + CW / 2;
    y = CH * (i / GX) + CH / 2;
    return 32'((x + 2 * y) >> 2);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic vsync_pulse();
    repeat (2) tick();
    vsync = 1'b0;
    repeat (3) tick();
    vsync = 1'b1;
    repeat (2) tick();
  endtask

  task automatic run_lines(input int mode, input int from, input int to);
    for (int y = from; y <= to; y++) begin
      for (int x = 0; x < int'(H); x++) begin
        video_on = 1'b1;
        pix_en   = 1'b1;
        rgb      = color(mode, x, y);
        if (y == rst_y && x == rst_x) begin
          reset = 1'b0;
          tick();
          reset = 1'b1;
          snap_we   = mem_we;
          snap_busy = busy;
        end else begin
          tick();
        end
      end
      video_on = 1'b0;
      pix_en   = 1'b0;
      repeat (4) tick();
    end
  endtask

  task automatic frame(input int mode);
    vsync_pulse();
    run_lines(mode, 0, V - 1);
    repeat (4) tick();
  endtask

  task automatic snap();
    base_wr   = wr_cnt;
    base_done = done_cnt;
    base_err  = err_cnt;
    base_low  = busy_low_cnt;
  endtask

  // Checks 16 logged writes starting at base: address order and data.
  task automatic chk_frame(input string tag, input int base, input int mode);
    logic [31:0] e;
    for (int i = 0; i < 16; i++) begin
      e = (mode == 1) ? 32'hFF : (mode == 2) ? 32'h7F : exp_grad(i);
      chk({tag, "_addr"}, 32'(wr_addr[base + i]), 32'(i));
      chk({tag, "_data"}, 32'(wr_data[base + i]), e);
    end
  endtask

  initial begin
    int bad;
    reset = 1'b0; start = 1'b0; continuous = 1'b0; vsync = 1'b1;
    video_on = 1'b0; pix_en = 1'b0; rgb = '0;
    snap_we = 1'b1; snap_busy = 1'b1;
    repeat (3) tick();
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    reset = 1'b1;
    repeat (2) tick();

    // Single shot, gradient pattern.
    snap();
    pulse_start();
    chk("t1_busy_armed", 32'(busy), 1);
    frame(0);
    chk("t1_writes", 32'(wr_cnt - base_wr), 16);
    chk("t1_done", 32'(done_cnt - base_done), 1);
    chk("t1_err", 32'(err_cnt - base_err), 0);
    chk("t1_busy_after", 32'(busy), 0);
    chk_frame("t1", base_wr, 0);
    snap();
    frame(0);
    chk("t1_idle_nowrite", 32'(wr_cnt - base_wr), 0);

    // Constant colours.
    snap();
    pulse_start();
    frame(1);
    chk("t2_white_writes", 32'(wr_cnt - base_wr), 16);
    chk_frame("t2_white", base_wr, 1);
    snap();
    pulse_start();
    frame(2);
    chk("t2_green_writes", 32'(wr_cnt - base_wr), 16);
    chk_frame("t2_green", base_wr, 2);

    // Start mid-frame: nothing until the next vsync.
    snap();
    vsync_pulse();
    run_lines(0, 0, 6);
    pulse_start();
    run_lines(0, 7, V - 1);
    repeat (4) tick();
    chk("t3_midframe_nowrite", 32'(wr_cnt - base_wr), 0);
    chk("t3_busy_armed", 32'(busy), 1);
    frame(0);
    chk("t3_writes", 32'(wr_cnt - base_wr), 16);
    chk("t3_done", 32'(done_cnt - base_done), 1);
    chk("t3_err", 32'(err_cnt - base_err), 0);
    chk_frame("t3", base_wr, 0);

    // Continuous mode over 3 frames, then drop continuous.
    continuous = 1'b1;
    pulse_start();
    snap();
    frame(0);
    frame(1);
    frame(0);
    chk("t4_writes", 32'(wr_cnt - base_wr), 48);
    chk("t4_done", 32'(done_cnt - base_done), 3);
    chk("t4_busy_low", 32'(busy_low_cnt - base_low), 0);
    chk("t4_busy", 32'(busy), 1);
    continuous = 1'b0;
    frame(0);
    chk("t4_writes4", 32'(wr_cnt - base_wr), 64);
    chk("t4_done4", 32'(done_cnt - base_done), 4);
    chk("t4_busy_after", 32'(busy), 0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (wr_addr[base_wr + i] != 4'(i % 16)) bad++;
    chk("t4_addr_order", 32'(bad), 0);
    chk_frame("t4_f2", base_wr + 16, 1);

    // Early vsync aborts after rows 0-1.
    snap();
    pulse_start();
    vsync_pulse();
    run_lines(0, 0, 7);
    vsync = 1'b0;
    repeat (3) tick();
    vsync = 1'b1;
    repeat (2) tick();
    chk("t5_abort_writes", 32'(wr_cnt - base_wr), 8);
    chk("t5_err", 32'(err_cnt - base_err), 1);
    chk("t5_no_done", 32'(done_cnt - base_done), 0);
    chk("t5_busy", 32'(busy), 1);
    run_lines(0, 0, V - 1);
    repeat (4) tick();
    chk("t5_writes", 32'(wr_cnt - base_wr), 24);
    chk("t5_done", 32'(done_cnt - base_done), 1);
    chk("t5_err_once", 32'(err_cnt - base_err), 1);
    chk_frame("t5", base_wr + 8, 0);

    // Reset mid-capture coinciding with a sample pixel (x=2, y=6).
    snap();
    pulse_start();
    vsync_pulse();
    rst_y = 6;
    rst_x = 2;
    run_lines(0, 0, 6);
    rst_y = -1;
    rst_x = -1;
    chk("t6_we_after_rst", 32'(snap_we), 0);
    chk("t6_busy_after_rst", 32'(snap_busy), 0);
    run_lines(0, 7, V - 1);
    frame(0);
    chk("t6_writes", 32'(wr_cnt - base_wr), 4);
    chk("t6_done", 32'(done_cnt - base_done), 0);
    chk("t6_err", 32'(err_cnt - base_err), 0);
    snap();
    pulse_start();
    frame(0);
    chk("t6_restart_writes", 32'(wr_cnt - base_wr), 16);
    chk("t6_restart_done", 32'(done_cnt - base_done), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
